// File: rtl/mio_ps2_tx.sv
// Host-to-device PS/2 transmitter. Sends one command byte to the keyboard:
// inhibit, request-to-send, then 8 data bits + odd parity + stop shifted out
// on device clock falls, with the device ACK sampled on the 11th fall.
module mio_ps2_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int RTS_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic [7:0] din,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_active,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  // One counter serves inhibit, RTS and timeout phases; size it for the largest.
  localparam int CMAX0 = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
  localparam int CMAX  = (CMAX0 > TIMEOUT_CYCLES) ? CMAX0 : TIMEOUT_CYCLES;
  localparam int CW    = $clog2(CMAX + 1);

  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] RTS_LAST = CW'(RTS_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SHIFT,
    S_WAIT_IDLE
  } state_t;

  state_t state_q, state_d;

  logic          clk_s1, clk_s2, clk_prev;
  logic          dat_s1, dat_s2;
  logic          fall;
  logic [7:0]    byte_q, byte_d;
  logic          par_q, par_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic          data_q, data_d;
  logic          ack_q, ack_d;
  logic          done_q, done_d;
  logic          tmo_q, tmo_d;

  // Pin synchronizers; idle-high reset values avoid a false fall after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_data_in;
      dat_s2   <= dat_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      byte_q  <= '0;
      par_q   <= 1'b0;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state logic. done/timeout are registered so they rise together with
  // the return to IDLE, which makes busy drop in the same cycle as the pulse.
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    par_d   = par_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    ack_d   = ack_q;
    done_d  = 1'b0;
    tmo_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (wr) begin
          byte_d  = din;
          par_d   = ~^din;
          ack_d   = 1'b0;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          cnt_d   = '0;
          state_d = S_RTS;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RTS: begin
        if (cnt_q == RTS_LAST) begin
          cnt_d   = '0;
          data_d  = 1'b1;  // keep the start bit on the line after clock release
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SHIFT: begin
        if (fall) begin
          cnt_d = '0;
          bit_d = bit_q + 4'd1;
          if (bit_q < 4'd8) begin
            data_d = ~byte_q[bit_q[2:0]];
          end else if (bit_q == 4'd8) begin
            data_d = ~par_q;
          end else if (bit_q == 4'd9) begin
            data_d = 1'b0;
          end else begin
            ack_d   = dat_s2;  // device pulls data low to acknowledge
            data_d  = 1'b0;
            state_d = S_WAIT_IDLE;
          end
        end else if (cnt_q == TMO_LAST) begin
          cnt_d   = '0;
          data_d  = 1'b0;
          ack_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WAIT_IDLE: begin
        if (clk_s2 && dat_s2) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (fall) begin
          cnt_d = '0;
        end else if (cnt_q == TMO_LAST) begin
          cnt_d   = '0;
          ack_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line drive is decoded from state so a reset releases both pins at once.
  assign ps2_clk_oe  = (state_q == S_INHIBIT) || (state_q == S_RTS);
  assign ps2_data_oe = (state_q == S_RTS) || ((state_q == S_SHIFT) && data_q);
  assign busy        = (state_q != S_IDLE);
  assign tx_active   = busy;
  assign done        = done_q;
  assign ack_err     = ack_q;
  assign timeout     = tmo_q;

endmodule

// File: tb/tb_mio_ps2_tx.sv
// Directed bench for mio_ps2_tx with a simple PS/2 device model on
// open-drain lines (device clock period 20 system clocks).
module tb_mio_ps2_tx;

  localparam int HALF = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_in, ps2_data_in;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       busy, tx_active, done, ack_err, timeout;

  logic [10:0] dev_bits;
  int total = 0;
  int bad = 0;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  always #5 clk = ~clk;

  mio_ps2_tx #(
    .INHIBIT_CYCLES(20),
    .RTS_CYCLES(4),
    .TIMEOUT_CYCLES(200)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr(wr),
    .din(din),
    .ps2_clk_in(ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy(busy),
    .tx_active(tx_active),
    .done(done),
    .ack_err(ack_err),
    .timeout(timeout)
  );

  // Device model: clocks falls [from,to), sampling data at the end of each high phase.
  task automatic dev_clock(input int from, input int to, input bit ack);
    for (int i = from; i < to; i++) begin
      repeat (HALF) @(negedge clk);
      dev_bits[i] = ps2_data_in;
      if (i == 10 && ack) dev_data = 1'b0;
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
    end
    dev_data = 1'b1;
  endtask

  task automatic issue_wr(input logic [7:0] d);
    @(negedge clk);
    wr = 1'b1;
    din = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic wait_release(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      if (busy && !ps2_clk_oe) ok = 1'b1;
      else @(negedge clk);
    end
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (ps2_clk_oe !== 1'b0) begin bad++; $display("FAIL reset_clk_oe got=%b exp=0", ps2_clk_oe); end
    total++; if (ps2_data_oe !== 1'b0) begin bad++; $display("FAIL reset_data_oe got=%b exp=0", ps2_data_oe); end
    total++; if ({busy, tx_active} !== 2'b00) begin bad++; $display("FAIL reset_busy got=%b exp=00", {busy, tx_active}); end
    total++; if ({done, ack_err, timeout} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {done, ack_err, timeout}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame_ed();
    int n_inh, n_rts;
    bit seen;
    @(negedge clk);
    wr = 1'b1;
    din = 8'hED;
    @(negedge clk);
    wr = 1'b0;
    total++; if ({busy, tx_active} !== 2'b11) begin bad++; $display("FAIL ed_busy got=%b exp=11", {busy, tx_active}); end
    n_inh = 0;
    while (ps2_clk_oe && !ps2_data_oe && n_inh < 100) begin n_inh++; @(negedge clk); end
    n_rts = 0;
    while (ps2_clk_oe && ps2_data_oe && n_rts < 100) begin n_rts++; @(negedge clk); end
    total++; if (n_inh !== 20) begin bad++; $display("FAIL ed_inhibit_len got=%0d exp=20", n_inh); end
    total++; if (n_rts !== 4) begin bad++; $display("FAIL ed_rts_len got=%0d exp=4", n_rts); end
    total++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b01) begin bad++; $display("FAIL ed_start_bit got=%b exp=01", {ps2_clk_oe, ps2_data_oe}); end
    dev_bits = '0;
    dev_clock(0, 11, 1'b1);
    total++; if (dev_bits !== 11'h7DA) begin bad++; $display("FAIL ed_bits got=%h exp=7da", dev_bits); end
    wait_done(seen);
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL ed_done got=%b exp=1", seen); end
    total++; if ({ack_err, busy} !== 2'b00) begin bad++; $display("FAIL ed_ack_busy got=%b exp=00", {ack_err, busy}); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL ed_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_parity();
    logic [7:0]  ds[3];
    logic [10:0] ex[3];
    bit ok, seen;
    ds[0] = 8'h01; ex[0] = 11'h402;
    ds[1] = 8'hFF; ex[1] = 11'h7FE;
    ds[2] = 8'h00; ex[2] = 11'h600;
    for (int k = 0; k < 3; k++) begin
      issue_wr(ds[k]);
      wait_release(ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL par_release%0d got=%b exp=1", k, ok); end
      dev_bits = '0;
      dev_clock(0, 11, 1'b1);
      total++; if (dev_bits !== ex[k]) begin bad++; $display("FAIL par_bits%0d got=%h exp=%h", k, dev_bits, ex[k]); end
      wait_done(seen);
      total++; if ({seen, ack_err} !== 2'b10) begin bad++; $display("FAIL par_done%0d got=%b exp=10", k, {seen, ack_err}); end
    end
  endtask

  // Ends on the very cycle done is visible, so the next test can write immediately.
  task automatic test_no_ack();
    bit ok, seen;
    issue_wr(8'h12);
    wait_release(ok);
    dev_bits = '0;
    dev_clock(0, 11, 1'b0);
    total++; if (dev_bits !== 11'h624) begin bad++; $display("FAIL noack_bits got=%h exp=624", dev_bits); end
    wait_done(seen);
    total++; if ({seen, ack_err} !== 2'b11) begin bad++; $display("FAIL noack_done got=%b exp=11", {seen, ack_err}); end
  endtask

  task automatic test_back_to_back();
    bit ok, seen;
    wr = 1'b1;
    din = 8'hF4;
    @(negedge clk);
    wr = 1'b0;
    total++; if ({busy, ack_err} !== 2'b10) begin bad++; $display("FAIL b2b_accept got=%b exp=10", {busy, ack_err}); end
    wait_release(ok);
    dev_bits = '0;
    dev_clock(0, 11, 1'b1);
    total++; if (dev_bits !== 11'h5E8) begin bad++; $display("FAIL b2b_bits got=%h exp=5e8", dev_bits); end
    wait_done(seen);
    total++; if ({seen, ack_err} !== 2'b10) begin bad++; $display("FAIL b2b_done got=%b exp=10", {seen, ack_err}); end
  endtask

  task automatic test_timeout();
    bit ok, seen, saw_done;
    int n;
    issue_wr(8'h55);
    wait_release(ok);
    dev_clock(0, 4, 1'b0);
    repeat (HALF) @(negedge clk);
    dev_clk = 1'b0;
    n = 0;
    seen = 1'b0;
    saw_done = 1'b0;
    while (!seen && n < 400) begin
      @(negedge clk);
      n++;
      if (n == HALF) dev_clk = 1'b1;
      if (done) saw_done = 1'b1;
      if (timeout) seen = 1'b1;
    end
    dev_clk = 1'b1;
    // 3 cycles of pin synchronization plus 200 cycles of timeout
    total++; if (seen !== 1'b1 || n !== 203) begin bad++; $display("FAIL tmo_latency got=%0d seen=%b exp=203", n, seen); end
    total++; if ({busy, ps2_clk_oe, ps2_data_oe} !== 3'b000) begin bad++; $display("FAIL tmo_release got=%b exp=000", {busy, ps2_clk_oe, ps2_data_oe}); end
    total++; if ({ack_err, saw_done} !== 2'b10) begin bad++; $display("FAIL tmo_flags got=%b exp=10", {ack_err, saw_done}); end
    @(negedge clk);
    total++; if (timeout !== 1'b0) begin bad++; $display("FAIL tmo_pulse got=%b exp=0", timeout); end
  endtask

  task automatic test_wr_ignored();
    bit ok, seen;
    issue_wr(8'hED);
    wait_release(ok);
    dev_bits = '0;
    dev_clock(0, 3, 1'b0);
    @(negedge clk);
    wr = 1'b1;
    din = 8'h00;
    @(negedge clk);
    wr = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ign_busy got=%b exp=1", busy); end
    dev_clock(3, 11, 1'b1);
    total++; if (dev_bits !== 11'h7DA) begin bad++; $display("FAIL ign_bits got=%h exp=7da", dev_bits); end
    wait_done(seen);
    total++; if ({seen, ack_err} !== 2'b10) begin bad++; $display("FAIL ign_done got=%b exp=10", {seen, ack_err}); end
  endtask

  task automatic test_reset_mid();
    bit ok, seen;
    issue_wr(8'hED);
    wait_release(ok);
    dev_clock(0, 4, 1'b0);
    @(negedge clk);
    wr = 1'b1;  // rst wins over a simultaneous write
    rst = 1'b1;
    @(negedge clk);
    total++; if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000) begin bad++; $display("FAIL rst_mid_release got=%b exp=000", {ps2_clk_oe, ps2_data_oe, busy}); end
    wr = 1'b0;
    rst = 1'b0;
    dev_clock(4, 11, 1'b1);
    wait_done(seen);
    total++; if ({seen, timeout, busy} !== 3'b000) begin bad++; $display("FAIL rst_mid_nodone got=%b exp=000", {seen, timeout, busy}); end
  endtask

  initial begin
    test_reset();
    test_frame_ed();
    test_parity();
    test_no_ack();
    test_back_to_back();
    test_timeout();
    test_wr_ignored();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
